pixel_streamer: RTL and testbench

PIXEL_STREAMER -- requirements
Module: pixel_streamer

---
 rtl/pixel_stream_pkg.sv | 25 ++
 rtl/pixel_streamer_if.sv | 42 ++++
 rtl/pixel_streamer_raster_counter.sv | 58 +++++
 rtl/pixel_streamer.sv | 135 +++++++++++++
 tb/tb_pixel_streamer.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/pixel_stream_pkg.sv
// Shared frame geometry, derived widths and streamer FSM state type.
// Also used by the sobel_filter integration.
package pixel_stream_pkg;

  localparam int unsigned ROW_WIDTH  = 256;
  localparam int unsigned HEIGHT     = 256;
  localparam int unsigned DATA_WIDTH = 8;

  // Keeps single-entry dimensions from collapsing to zero-width vectors.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  localparam int unsigned ColBits  = clog2_min1(ROW_WIDTH);
  localparam int unsigned RowBits  = clog2_min1(HEIGHT);
  localparam int unsigned AddrBits = clog2_min1(ROW_WIDTH * HEIGHT);

  typedef enum logic [1:0] {
    StIdle,
    StStream,
    StGap,
    StDrain
  } state_e;

endpackage

// File: rtl/pixel_streamer_if.sv
// Control, frame-memory read and pixel-output signals of pixel_streamer.
// The master modport is the streamer side; the slave modport is its environment.
interface pixel_streamer_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 16
) ();

  logic                  start;
  logic                  hold;
  logic                  mem_en;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic [DATA_WIDTH-1:0] pixel;
  logic                  recv_data;
  logic                  busy;
  logic                  frame_done;

  modport master (
    input  start,
    input  hold,
    input  mem_rdata,
    output mem_en,
    output mem_addr,
    output pixel,
    output recv_data,
    output busy,
    output frame_done
  );

  modport slave (
    output start,
    output hold,
    output mem_rdata,
    input  mem_en,
    input  mem_addr,
    input  pixel,
    input  recv_data,
    input  busy,
    input  frame_done
  );

endinterface

// File: rtl/pixel_streamer_raster_counter.sv
// Row/column raster position counter for pixel_streamer (module raster_counter).
// Advances one pixel per inc_i, wrapping column into row and row back to zero.
module raster_counter import pixel_stream_pkg::*; #(
  parameter int unsigned RowWidth = ROW_WIDTH,
  parameter int unsigned Height   = HEIGHT,
  parameter int unsigned ColW     = clog2_min1(RowWidth),
  parameter int unsigned RowW     = clog2_min1(Height)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            inc_i,
  input  logic            clear_i,
  output logic [ColW-1:0] col_o,
  output logic [RowW-1:0] row_o,
  output logic            last_col_o,
  output logic            last_pixel_o
);

  logic [ColW-1:0] col_q, col_d;
  logic [RowW-1:0] row_q, row_d;
  logic            last_col;
  logic            last_row;

  assign last_col = (col_q == ColW'(RowWidth - 1));
  assign last_row = (row_q == RowW'(Height - 1));

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (clear_i) begin
      col_d = '0;
      row_d = '0;
    end else if (inc_i) begin
      if (last_col) begin
        col_d = '0;
        row_d = last_row ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

  assign col_o        = col_q;
  assign row_o        = row_q;
  assign last_col_o   = last_col;
  assign last_pixel_o = last_col && last_row;

endmodule

// File: rtl/pixel_streamer.sv
// Streams one frame from a 1-cycle-latency frame memory as a raster pixel strobe.
// Define PIXEL_STREAMER_GAP_EN to insert GAP_CYCLES blank cycles between rows.
module pixel_streamer #(
  parameter int unsigned ROW_WIDTH  = pixel_stream_pkg::ROW_WIDTH,
  parameter int unsigned HEIGHT     = pixel_stream_pkg::HEIGHT,
  parameter int unsigned DATA_WIDTH = pixel_stream_pkg::DATA_WIDTH,
  parameter int unsigned GAP_CYCLES = 4
) (
  input logic              clk,
  input logic              rst,
  pixel_streamer_if.master bus
);

  import pixel_stream_pkg::*;

  localparam int unsigned ColW  = clog2_min1(ROW_WIDTH);
  localparam int unsigned RowW  = clog2_min1(HEIGHT);
  localparam int unsigned AddrW = clog2_min1(ROW_WIDTH * HEIGHT);

  state_e                state_q, state_d;
  logic                  recv_data_q, recv_data_d;
  logic [DATA_WIDTH-1:0] pixel_q, pixel_d;
  logic                  mem_en;
  logic                  inc;
  logic                  clear;
  logic [ColW-1:0]       col;
  logic [RowW-1:0]       row;
  logic                  last_col;
  logic                  last_pixel;

`ifdef PIXEL_STREAMER_GAP_EN
  localparam int unsigned GapW = clog2_min1(GAP_CYCLES);
  logic [GapW-1:0] gap_q, gap_d;
`endif

  raster_counter #(
    .RowWidth(ROW_WIDTH),
    .Height  (HEIGHT),
    .ColW    (ColW),
    .RowW    (RowW)
  ) u_raster (
    .clk_i       (clk),
    .rst_ni      (rst),
    .inc_i       (inc),
    .clear_i     (clear),
    .col_o       (col),
    .row_o       (row),
    .last_col_o  (last_col),
    .last_pixel_o(last_pixel)
  );

  always_comb begin
    state_d = state_q;
    mem_en  = 1'b0;
    inc     = 1'b0;
    clear   = 1'b0;
`ifdef PIXEL_STREAMER_GAP_EN
    gap_d   = gap_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          clear   = 1'b1;
          state_d = StStream;
        end
      end
      StStream: begin
        // A held read leaves row/col untouched, so a wrap simply waits for the next issued read.
        mem_en = !bus.hold;
        inc    = mem_en;
        if (mem_en && last_col) begin
          if (last_pixel) begin
            state_d = StDrain;
          end
`ifdef PIXEL_STREAMER_GAP_EN
          else if (GAP_CYCLES != 0) begin
            state_d = StGap;
            gap_d   = '0;
          end
`endif
        end
      end
`ifdef PIXEL_STREAMER_GAP_EN
      StGap: begin
        if (gap_q == GapW'(GAP_CYCLES - 1)) begin
          state_d = StStream;
          gap_d   = '0;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
`endif
      StDrain: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Read data returns alongside the registered enable and is passed straight through.
  assign recv_data_d = mem_en;
  assign pixel_d     = recv_data_q ? bus.mem_rdata : pixel_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      recv_data_q <= 1'b0;
      pixel_q     <= '0;
    end else begin
      state_q     <= state_d;
      recv_data_q <= recv_data_d;
      pixel_q     <= pixel_d;
    end
  end

`ifdef PIXEL_STREAMER_GAP_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gap_q <= '0;
    end else begin
      gap_q <= gap_d;
    end
  end
`endif

  assign bus.mem_en     = mem_en;
  assign bus.mem_addr   = AddrW'(row) * AddrW'(ROW_WIDTH) + AddrW'(col);
  assign bus.pixel      = pixel_d;
  assign bus.recv_data  = recv_data_q;
  assign bus.busy       = (state_q != StIdle);
  assign bus.frame_done = (state_q == StDrain);

endmodule

// File: tb/tb_pixel_streamer.sv
// Scoreboard bench for pixel_streamer on a 4x4 frame with mem[a] = a[7:0].
// Honours PIXEL_STREAMER_GAP_EN when computing expected pulse spacing.
module tb_pixel_streamer;

  localparam int Rw = 4;
  localparam int Ht = 4;
  localparam int Np = Rw * Ht;
`ifdef PIXEL_STREAMER_GAP_EN
  localparam int GapExp = 4;
`else
  localparam int GapExp = 0;
`endif

  typedef struct {
    int data;
    bit fd;
    int gap;
  } exp_t;

  logic clk;
  logic rst;

  pixel_streamer_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) bus ();

  pixel_streamer #(
    .ROW_WIDTH (Rw),
    .HEIGHT    (Ht),
    .DATA_WIDTH(8),
    .GAP_CYCLES(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  exp_t exp_q[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   fd_cnt = 0;
  int   fd_cyc = -100;
  int   last_cyc = -100;
  int   first_cyc = -100;
  int   last_pix = 0;
  int   hold_mode = 0;
  bit   v6_done = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  // Frame memory with one cycle of read latency; junk when no read is issued.
  always @(posedge clk) begin
    if (bus.mem_en) bus.mem_rdata <= 8'(bus.mem_addr);
    else            bus.mem_rdata <= 8'hEE;
  end

  task automatic check(input string name, input int act, input int exp);
    total = total + 1;
    if (act != exp) begin
      bad = bad + 1;
      $display("FAIL %s: got %0d want %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops the scoreboard on every pulse.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        last_pix = 0;
      end else begin
        if (bus.recv_data) begin
          if (exp_q.size() == 0) begin
            check("unexpected_pulse", int'(bus.pixel), -1);
          end else begin
            e = exp_q.pop_front();
            check("pixel", int'(bus.pixel), e.data);
            check("frame_done_on_pulse", int'(bus.frame_done), int'(e.fd));
            if (e.gap >= 0) check("pulse_spacing", cyc - last_cyc, e.gap);
            if (e.data == 0) first_cyc = cyc;
          end
          last_cyc = cyc;
          last_pix = int'(bus.pixel);
        end else begin
          check("pixel_hold", int'(bus.pixel), last_pix);
          if (bus.frame_done) check("stray_frame_done", 1, 0);
        end
        if (bus.frame_done) begin
          fd_cnt = fd_cnt + 1;
          fd_cyc = cyc;
        end
      end
    end
  end

  // hold driver: mode 1 = odd cycles, mode 6 = one cycle on the row-0 col-3 read.
  initial forever begin
    @(negedge clk);
    case (hold_mode)
      1:       bus.hold = cyc[0];
      6: begin
        if (!v6_done && bus.busy && bus.mem_addr == 4'd3) begin
          bus.hold = 1'b1;
          v6_done  = 1'b1;
        end else begin
          bus.hold = 1'b0;
        end
      end
      default: bus.hold = 1'b0;
    endcase
  end

  task automatic push_frame(input int mode);
    exp_t e;
    for (int i = 0; i < Np; i++) begin
      e.data = i;
      e.fd   = (i == Np - 1);
      if (i == 0)           e.gap = -1;
      else if (mode == 1)   e.gap = -1;
      else if (i % Rw == 0) e.gap = 1 + GapExp;
      else                  e.gap = 1;
      if (mode == 6 && i == 3) e.gap = 2;
      exp_q.push_back(e);
    end
  endtask

  task automatic do_start();
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_frame_end();
    int n = 0;
    while (bus.busy && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("frame_end_timeout", int'(bus.busy), 0);
    check("busy_drop_after_done", cyc - fd_cyc, 1);
    check("scoreboard_empty", exp_q.size(), 0);
  endtask

  task automatic wait_pixel(input int k);
    int n = 0;
    while (!(bus.recv_data && int'(bus.pixel) == k) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("wait_pixel_timeout", int'(bus.recv_data && int'(bus.pixel) == k), 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int fd0;
    int n;
    rst       = 1'b0;
    bus.start = 1'b0;
    bus.hold  = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_recv_data", int'(bus.recv_data), 0);
    check("rst_frame_done", int'(bus.frame_done), 0);
    check("rst_pixel", int'(bus.pixel), 0);
    check("rst_mem_en", int'(bus.mem_en), 0);
    check("rst_mem_addr", int'(bus.mem_addr), 0);
    rst = 1'b1;
    @(negedge clk);

    // V1/V3: free-running frame, spacing reflects the gap build option.
    fd0 = fd_cnt;
    push_frame(0);
    do_start();
    check("busy_after_start", int'(bus.busy), 1);
    wait_frame_end();
    check("v1_frame_span", last_cyc - first_cyc + 1, Np + (Ht - 1) * GapExp);
    check("v1_frames", fd_cnt - fd0, 1);

    // V2: hold on every odd cycle.
    fd0 = fd_cnt;
    hold_mode = 1;
    push_frame(1);
    do_start();
    wait_frame_end();
    hold_mode = 0;
    check("v2_frames", fd_cnt - fd0, 1);

    // V6: one-cycle hold on the row-wrap read.
    fd0 = fd_cnt;
    v6_done = 1'b0;
    hold_mode = 6;
    push_frame(6);
    do_start();
    wait_frame_end();
    hold_mode = 0;
    check("v6_frames", fd_cnt - fd0, 1);

    // V4: extra starts mid-frame and on the frame_done cycle.
    fd0 = fd_cnt;
    push_frame(0);
    do_start();
    wait_pixel(5);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    n = 0;
    while (!bus.frame_done && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("v4_done_timeout", int'(bus.frame_done), 1);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    check("v4_busy_after_done", int'(bus.busy), 0);
    repeat (20) @(negedge clk);
    check("v4_still_idle", int'(bus.busy), 0);
    check("v4_frames", fd_cnt - fd0, 1);
    check("v4_scoreboard_empty", exp_q.size(), 0);

    // V5: reset mid-frame, then a fresh frame from address 0.
    fd0 = fd_cnt;
    push_frame(0);
    do_start();
    wait_pixel(9);
    #1;
    rst = 1'b0;
    #1;
    check("v5_busy", int'(bus.busy), 0);
    check("v5_recv_data", int'(bus.recv_data), 0);
    check("v5_frame_done", int'(bus.frame_done), 0);
    check("v5_pixel", int'(bus.pixel), 0);
    check("v5_mem_en", int'(bus.mem_en), 0);
    check("v5_mem_addr", int'(bus.mem_addr), 0);
    exp_q.delete();
    repeat (3) @(negedge clk);
    check("v5_no_frame_done", fd_cnt - fd0, 0);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("v5_idle_after_release", int'(bus.busy), 0);
    check("v5_no_pulse_after_release", int'(bus.recv_data), 0);
    push_frame(0);
    do_start();
    wait_frame_end();
    check("v5_restart_frames", fd_cnt - fd0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
